// File: rtl/pulse_to_level.sv
// pulse_to_level: stretches single-cycle event pulses into fixed-width level windows, each followed by a guaranteed low gap
module pulse_to_level #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int RETRIGGER   = 0,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic              done,
  output logic              pending,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic level_q, level_d, busy_q, busy_d, done_q, done_d, pending_q, pending_d, drop;
  logic [DROP_W-1:0] drop_q, drop_d;
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    drop      = 1'b0;
    case (state_q)
      IDLE: if (pulse_in) begin
        state_d = HIGH;
        hold_d  = HOLD_LD;
      end
      HIGH: begin
        if (RETRIGGER != 0 && pulse_in) hold_d = HOLD_LD;
        else if (hold_q == '0) begin
          state_d = GAP;
          gap_d   = GAP_LD;
          done_d  = 1'b1;
        end else hold_d = hold_q - HW'(1);
        if (RETRIGGER == 0 && pulse_in) begin
          pending_d = 1'b1;
          drop      = pending_q;
        end
      end
      GAP: if (gap_q == '0) begin
        // a pending event is consumed here; a simultaneous pulse takes its slot without a drop
        state_d   = (pending_q || pulse_in) ? HIGH : IDLE;
        hold_d    = HOLD_LD;
        pending_d = pending_q && pulse_in;
      end else begin
        gap_d = gap_q - GW'(1);
        if (pulse_in) begin
          pending_d = 1'b1;
          drop      = pending_q;
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = state_d == HIGH;
    busy_d  = state_d != IDLE;
    drop_d  = (drop && !(&drop_q)) ? drop_q + DROP_W'(1) : drop_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      gap_q     <= '0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end
  assign level_out = level_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_pulse_to_level.sv
// tb_pulse_to_level: drives a non-retriggering and a retriggering instance with the same pulses and
// compares both against a window-start-timestamp model of the event rules
module tb_pulse_to_level;
  localparam int H = 4;
  localparam int G = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse_in = 1'b0;
  logic lvl[2], bsy[2], dn[2], pnd[2];
  logic [7:0] drp[2];
  int total = 0;
  int bad = 0;
  int t = 0;
  bit m_act[2];
  int m_s[2];
  bit m_pend[2];
  int m_drop[2];

  always #5 clk = ~clk;

  pulse_to_level #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .RETRIGGER(0), .DROP_W(8)) u_q (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .level_out(lvl[0]), .busy(bsy[0]),
    .done(dn[0]), .pending(pnd[0]), .drop_cnt(drp[0]));
  pulse_to_level #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .RETRIGGER(1), .DROP_W(8)) u_r (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .level_out(lvl[1]), .busy(bsy[1]),
    .done(dn[1]), .pending(pnd[1]), .drop_cnt(drp[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_s[d] = 0; m_pend[d] = 0; m_drop[d] = 0;
    end
  endtask

  task automatic enq(input int d);
    if (m_pend[d]) m_drop[d] = m_drop[d] < 255 ? m_drop[d] + 1 : 255;
    else m_pend[d] = 1;
  endtask

  // window started (level rose) after edge s: high after s..s+H-1, low/done after s+H,
  // gap edges up to s+H+G-1, decision edge s+H+G
  task automatic model_step(input int d, input bit p);
    int s;
    s = m_s[d];
    if (!m_act[d]) begin
      if (p) begin m_act[d] = 1; m_s[d] = t; end
    end else if (t <= s + H) begin
      if (d == 1 && p) m_s[d] = t;
      else if (p) enq(d);
    end else if (t < s + H + G) begin
      if (p) enq(d);
    end else if (m_pend[d] || p) begin
      m_s[d] = t;
      m_pend[d] = m_pend[d] && p;
    end else m_act[d] = 0;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk(d ? "level_r" : "level_q", lvl[d], m_act[d] && t < m_s[d] + H);
      chk(d ? "busy_r" : "busy_q", bsy[d], m_act[d]);
      chk(d ? "done_r" : "done_q", dn[d], m_act[d] && t == m_s[d] + H);
      chk(d ? "pend_r" : "pend_q", pnd[d], m_pend[d]);
      chk(d ? "drop_r" : "drop_q", drp[d], m_drop[d]);
    end
  endtask

  task automatic cycle(input bit p);
    pulse_in = p;
    @(posedge clk);
    t++;
    for (int d = 0; d < 2; d++) model_step(d, p);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0);
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    #10 rst = 1'b0;
    idle(3);
    cycle(1); idle(12);
    cycle(1); cycle(0); cycle(1); idle(14);
    cycle(1); cycle(0); cycle(1); cycle(1); idle(16);
    cycle(1); cycle(0); cycle(1); cycle(0); cycle(0); cycle(0); cycle(1); idle(20);
    for (int i = 0; i < 1500; i++) cycle($urandom_range(0, 3) == 0);
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 1) == 0);
    idle(12);
    cycle(1); cycle(1); cycle(0); cycle(1);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    #1 rst = 1'b0;
    idle(2);
    cycle(1); idle(12);
    for (int i = 0; i < 2000; i++) cycle(1);
    chk("drop_sat", drp[0], 255);
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_to_level.md
Name: pulse_to_level

Overview:
- Inverse of the edge-detect stage: converts single-cycle event pulses (e.g. a filter-trigger strobe) back into a clean level window of fixed width.
- Each window is followed by a guaranteed low gap, so a downstream posedge detector sees one rising edge per accepted event.
- Sits in the symmetric FIR control path, between the trigger/strobe source and the filter-enable input of the datapath.
- Provides a busy indication, an end-of-window strobe, a one-deep pending slot and a saturating count of dropped events.

Parameters:
- HOLD_CYCLES, 4: number of cycles level_out is held high per accepted event; must be >= 1.
- GAP_CYCLES, 2: minimum number of low cycles after each window; must be >= 1.
- RETRIGGER, 0: 0 = pulses during a window are queued; 1 = pulses during HIGH extend the window.
- DROP_W, 8: width of drop_cnt.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: asynchronous, active-high.
- pulse_in  in  1  event input; every sampled high cycle is one event.
- level_out  out  1  registered level window.
- busy  out  1  high in HIGH or GAP.
- done  out  1  one-cycle strobe on the first low cycle after a window.
- pending  out  1  a queued event is waiting.
- drop_cnt  out  DROP_W  saturating count of discarded events.

Behaviour:
- Reset (async, immediate): state=IDLE; level_out, busy, done, pending, drop_cnt all 0; counters cleared. Reset mid-window drops the window and any pending event.
- States: IDLE, HIGH, GAP. All outputs are registered; no combinational path from pulse_in.
- IDLE: pulse_in=1 at edge k -> after edge k: HIGH, level_out=1, hold_cnt=HOLD_CYCLES-1. Latency from pulse to level is 1 clock.
- HIGH, each edge:
  - If RETRIGGER=1 and pulse_in=1: hold_cnt reloads to HOLD_CYCLES-1 and the state stays HIGH. This also applies on the hold_cnt==0 cycle.
  - Otherwise, if hold_cnt==0: go to GAP, with level_out=0, done=1 for one cycle, gap_cnt=GAP_CYCLES-1.
  - Otherwise: hold_cnt decrements.
  - Result: level_out is high exactly HOLD_CYCLES cycles per non-extended window.
- GAP, each edge:
  - If gap_cnt==0 and (pending or pulse_in): go to HIGH, level_out=1, hold_cnt reloaded.
  - If gap_cnt==0 otherwise: go to IDLE.
  - Else: gap_cnt decrements.
  - Result: level_out is low for at least GAP_CYCLES cycles.
- Queueing (RETRIGGER=0 in HIGH/GAP; RETRIGGER=1 in GAP only):
  - pulse_in=1 with pending=0: set pending.
  - pulse_in=1 with pending=1: drop the event; drop_cnt increments.
- Simultaneous events:
  - Pending is consumed at the GAP->HIGH edge and pulse_in=1 on that same edge: pulse_in becomes the new pending, with no drop.
  - Pulse on the last GAP cycle with pending=0: starts the new window directly; pending stays 0.
- drop_cnt saturates at 2^DROP_W-1; it never wraps. It is cleared only by rst.
- busy=1 exactly when the state is HIGH or GAP. done=0 at all other times.
- pulse_in held high continuously: every sampled high cycle is a separate event.
  - RETRIGGER=1: the window stays extended.
  - RETRIGGER=0: pending refills each window and the excess events are counted as drops.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2, DROP_W=8 unless noted):
1. Assert rst mid-simulation while in HIGH -> level_out, busy, pending, drop_cnt go to 0 without waiting for a clock edge. First pulse after release gives a normal 4-cycle window.
2. Single pulse sampled at edge 10 -> level_out=1 after edges 10..13 and 0 from edge 14. done=1 only after edge 14. busy=1 after edges 10..15; state is IDLE after edge 16.
3. RETRIGGER=0, pulses sampled at edges 0 and 2 -> level high 4 cycles, low 2 cycles, high 4 cycles. pending=1 after edges 2..5; drop_cnt=0. Adding a third pulse at edge 3 -> drop_cnt=1, still two windows.
4. RETRIGGER=1, pulses at edges 0 and 2 -> single window with level_out high 6 consecutive cycles, one done strobe, drop_cnt=0.
5. RETRIGGER=0, pending set and pulse_in=1 on the last GAP edge -> next window starts and pending remains 1 -> three back-to-back windows separated by exactly 2 low cycles.
6. RETRIGGER=0, pulse_in held high for 2000 cycles -> drop_cnt reaches 255 and stays 255. Windows continue at a period of 6 cycles.
